// File: rtl/tb_pkg.sv
// tb_pkg: shared state encoding, error code and default addresses for the test controller.
package tb_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;
  localparam logic [31:0] ERR_TIMEOUT = 32'hFFFF_FFFF;
  localparam logic [31:0] TOHOST_DEF  = 32'h0000_1000;
  localparam logic [31:0] PUTC_DEF    = 32'h0000_1004;
endpackage

// File: rtl/tb_char_fifo.sv
// tb_char_fifo: first-word fall-through byte FIFO; extra pointer bit separates full from empty.
module tb_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic wr, rd;
  always_comb begin
    empty_o = wptr_q == rptr_q;
    full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    wr      = push_i & ~full_o;
    rd      = pop_i & ~empty_o;
    wptr_d  = wr ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = rd ? rptr_q + (AW+1)'(1) : rptr_q;
    dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/tb_test_controller.sv
// tb_test_controller: sequences a CPU simulation run, decodes tohost/putc writes,
// enforces a RUN-cycle watchdog and buffers console bytes.
module tb_test_controller import tb_pkg::*; #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_DEF),
  parameter logic [ADDR_W-1:0] PUTC_ADDR   = ADDR_W'(PUTC_DEF),
  parameter int                TIMEOUT     = 100000,
  parameter int                CNT_W       = 32,
  parameter int                FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_be,
  output logic              done,
  output logic              passed,
  output logic [31:0]       error_code,
  output logic [CNT_W-1:0]  cycles,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              char_overflow
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [31:0] err_q, err_d;
  logic ovf_q, ovf_d;
  logic run, verdict, expire, push, full, empty;
  always_comb begin
    run     = state_q == S_RUN;
    verdict = run & bus_we & (bus_addr == TOHOST_ADDR) & (bus_be == 4'hF) & bus_wdata[0];
    expire  = run & (cycles_q == CNT_W'(TIMEOUT - 1));
    push    = bus_we & (bus_addr == PUTC_ADDR) & bus_be[0] & (state_q != S_IDLE);
    state_d = state_q;
    err_d   = err_q;
    if (state_q == S_IDLE && start) state_d = S_RUN;
    else if (verdict) begin
      state_d = (bus_wdata == 32'd1) ? S_PASS : S_FAIL;
      err_d   = (bus_wdata == 32'd1) ? 32'd0 : {1'b0, bus_wdata[31:1]};
    end else if (expire) begin
      state_d = S_TIMEOUT;
      err_d   = ERR_TIMEOUT;
    end
    // the counter only advances on cycles that stay in RUN, so it freezes on the deciding edge
    cycles_d      = (run && state_d == S_RUN && ~&cycles_q) ? cycles_q + CNT_W'(1) : cycles_q;
    ovf_d         = ovf_q | (push & full);
    done          = state_q inside {S_PASS, S_FAIL, S_TIMEOUT};
    passed        = state_q == S_PASS;
    error_code    = err_q;
    cycles        = cycles_q;
    char_valid    = ~empty;
    char_overflow = ovf_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cycles_q <= '0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end
  tb_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (char_ready),
    .din_i   (bus_wdata[7:0]),
    .dout_o  (char_data),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_tb_test_controller.sv
// tb_tb_test_controller: scoreboard bench for the test controller, run with a 20-cycle watchdog.
module tb_tb_test_controller;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam logic [31:0] PUTC   = 32'h0000_1004;
  logic clk = 0, reset = 1, start = 0, bus_we = 0, char_ready = 0;
  logic [31:0] bus_addr = 0, bus_wdata = 0;
  logic [3:0] bus_be = 0;
  logic done, passed, char_valid, char_overflow;
  logic [31:0] error_code, cycles;
  logic [7:0] char_data;
  int n_chk = 0, n_fail = 0, n_pop = 0;
  logic [7:0] sb[$];
  tb_test_controller #(.TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .done(done), .passed(passed),
    .error_code(error_code), .cycles(cycles), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .char_overflow(char_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // pops are decided mid-cycle, one half-period before the edge that performs them
  always @(negedge clk) begin
    if (!reset && char_valid && char_ready) begin
      if (sb.size() == 0) chk("char_unexpected", char_valid, 0);
      else begin
        chk("char_data", char_data, sb.pop_front());
        n_pop++;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_we = 1; bus_addr = a; bus_wdata = d; bus_be = be;
    tick();
    bus_we = 0; bus_addr = 0; bus_wdata = 0; bus_be = 0;
  endtask
  task automatic putc(input logic [7:0] c, input bit live);
    if (live && sb.size() < 8) sb.push_back(c);
    wr(PUTC, {24'h0, c}, 4'h1);
  endtask
  task automatic do_reset();
    reset = 1; start = 0; char_ready = 0;
    sb.delete();
    tick(); tick();
    reset = 0;
  endtask
  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic drain();
    char_ready = 1;
    for (int i = 0; i < 20 && char_valid; i++) tick();
    chk("drain_valid", char_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);
    char_ready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end
  initial begin
    int n;
    do_reset();
    chk("rst_done", done, 0);
    chk("rst_passed", passed, 0);
    chk("rst_err", error_code, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_valid", char_valid, 0);
    chk("rst_data", char_data, 0);
    chk("rst_ovf", char_overflow, 0);
    wr(TOHOST, 1, 4'hF);
    putc("x", 0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_valid", char_valid, 0);
    chk("idle_cycles", cycles, 0);
    go();
    for (int i = 0; i < 10; i++) tick();
    chk("pass_pre_done", done, 0);
    wr(TOHOST, 1, 4'hF);
    chk("pass_done", done, 1);
    chk("pass_passed", passed, 1);
    chk("pass_err", error_code, 0);
    chk("pass_cycles", cycles, 10);
    go();
    chk("pass_start_ignored", cycles, 10);
    do_reset();
    go();
    wr(TOHOST, 7, 4'h7);
    wr(TOHOST, 6, 4'hF);
    wr(TOHOST + 4, 7, 4'hF);
    chk("fail_ignored", done, 0);
    wr(TOHOST, 7, 4'hF);
    chk("fail_done", done, 1);
    chk("fail_passed", passed, 0);
    chk("fail_err", error_code, 3);
    chk("fail_cycles", cycles, 3);
    wr(TOHOST, 1, 4'hF);
    tick();
    chk("fail_sticky_passed", passed, 0);
    chk("fail_sticky_err", error_code, 3);
    chk("fail_frozen", cycles, 3);
    do_reset();
    go();
    n = 0;
    while (n < 40 && !done) begin
      tick();
      n++;
    end
    chk("to_latency", n, 20);
    chk("to_err", error_code, 32'hFFFF_FFFF);
    chk("to_passed", passed, 0);
    chk("to_cycles", cycles, 19);
    tick(); tick(); tick();
    chk("to_frozen", cycles, 19);
    do_reset();
    go();
    for (int i = 0; i < 19; i++) tick();
    chk("tie_pre_done", done, 0);
    chk("tie_pre_cycles", cycles, 19);
    wr(TOHOST, 1, 4'hF);
    chk("tie_passed", passed, 1);
    chk("tie_err", error_code, 0);
    do_reset();
    go();
    for (int i = 0; i < 9; i++) begin
      putc(8'("A" + i), 1);
      chk($sformatf("ovf_%0d", i), char_overflow, i == 8);
    end
    chk("fifo_head", char_data, "A");
    drain();
    chk("drain_count", n_pop, 8);
    do_reset();
    go();
    for (int i = 0; i < 8; i++) putc(8'("a" + i), 1);
    chk("full_no_ovf", char_overflow, 0);
    char_ready = 1;
    putc("Z", 1);
    chk("full_pop_push_ovf", char_overflow, 1);
    drain();
    char_ready = 1;
    for (int i = 0; i < 5; i++) putc(8'("0" + i), 1);
    drain();
    do_reset();
    go();
    for (int i = 0; i < 3; i++) putc(8'("p" + i), 1);
    chk("q3_valid", char_valid, 1);
    reset = 1;
    #2;
    chk("arst_valid", char_valid, 0);
    chk("arst_data", char_data, 0);
    chk("arst_cycles", cycles, 0);
    chk("arst_done", done, 0);
    sb.delete();
    tick();
    reset = 0;
    wr(TOHOST, 1, 4'hF);
    putc("q", 0);
    tick();
    chk("arst_idle_done", done, 0);
    chk("arst_idle_cycles", cycles, 0);
    chk("arst_idle_valid", char_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
